// File: rtl/softmax_pkg.sv
// Shared constants and FSM state type for the softmax lane serializer.
package softmax_pkg;

    localparam int SM_SIZE    = 5;
    localparam int SM_WID_OUT = 17;
    localparam int SM_IDX_W   = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sm_state_e;

endpackage

// File: rtl/softmax_argmax_track.sv
// Running maximum over the beats of one vector; pulses the winning lane index
// after the final beat. Strictly-greater update makes the lowest index win ties.
module softmax_argmax_track
    import softmax_pkg::*;
#(
    parameter int wid_out = SM_WID_OUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                beat_i,
    input  logic                first_i,
    input  logic                last_i,
    input  logic [SM_IDX_W-1:0] idx_i,
    input  logic [wid_out-1:0]  data_i,
    output logic [SM_IDX_W-1:0] argmax_idx_o,
    output logic                argmax_valid_o
);

    logic [wid_out-1:0]  max_q, max_d;
    logic [SM_IDX_W-1:0] max_idx_q, max_idx_d;
    logic [SM_IDX_W-1:0] res_idx_q, res_idx_d;
    logic                pulse_q, pulse_d;
    logic [wid_out-1:0]  win_data_s;
    logic [SM_IDX_W-1:0] win_idx_s;

    // Winner of the current beat against the running maximum, and next state.
    always_comb begin
        win_data_s = max_q;
        win_idx_s  = max_idx_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        res_idx_d  = res_idx_q;
        pulse_d    = 1'b0;
        if (first_i || (data_i > max_q)) begin
            win_data_s = data_i;
            win_idx_s  = idx_i;
        end else begin
            win_data_s = max_q;
            win_idx_s  = max_idx_q;
        end
        if (beat_i) begin
            max_d     = win_data_s;
            max_idx_d = win_idx_s;
            if (last_i) begin
                res_idx_d = win_idx_s;
                pulse_d   = 1'b1;
            end else begin
                res_idx_d = res_idx_q;
                pulse_d   = 1'b0;
            end
        end else begin
            max_d     = max_q;
            max_idx_d = max_idx_q;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q     <= {wid_out{1'b0}};
            max_idx_q <= {SM_IDX_W{1'b0}};
            res_idx_q <= {SM_IDX_W{1'b0}};
            pulse_q   <= 1'b0;
        end else begin
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            res_idx_q <= res_idx_d;
            pulse_q   <= pulse_d;
        end
    end

    assign argmax_idx_o   = res_idx_q;
    assign argmax_valid_o = pulse_q;

endmodule

// File: rtl/softmax_stream_out.sv
// Captures a parallel softmax vector and streams its lanes one per beat.
// Optional argmax tracking is enabled by defining SOFTMAX_ARGMAX_EN.
module softmax_stream_out
    import softmax_pkg::*;
#(
    parameter int size    = SM_SIZE,
    parameter int wid_out = SM_WID_OUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [wid_out-1:0]  prob [1:size],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [wid_out-1:0]  out_data,
    output logic [SM_IDX_W-1:0] out_idx,
    output logic                out_last,
    output logic [SM_IDX_W-1:0] argmax_idx,
    output logic                argmax_valid
);

    localparam logic [SM_IDX_W-1:0] LAST_IDX = SM_IDX_W'(size - 1);

    sm_state_e           state_q, state_d;
    logic [SM_IDX_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [wid_out-1:0]  data_q, data_d, next_lane_s;
    logic                last_q, last_d;
    logic [wid_out-1:0]  bank_q [0:size-1];
    logic [wid_out-1:0]  bank_d [0:size-1];

    assign cnt_inc_s = cnt_q + SM_IDX_W'(1);

    // Select the lane that follows the one currently presented.
    always_comb begin
        next_lane_s = {wid_out{1'b0}};
        for (int i = 0; i < size; i++) begin
            next_lane_s = (cnt_inc_s == SM_IDX_W'(i)) ? bank_q[i] : next_lane_s;
        end
    end

    // Next-state logic: capture in IDLE, advance on each accepted beat in SEND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        for (int i = 0; i < size; i++) begin
            bank_d[i] = bank_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < size; i++) begin
                        bank_d[i] = prob[i+1];
                    end
                    cnt_d   = {SM_IDX_W{1'b0}};
                    data_d  = prob[1];
                    last_d  = (LAST_IDX == {SM_IDX_W{1'b0}});
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d  = cnt_inc_s;
                        data_d = next_lane_s;
                        last_d = (cnt_inc_s == LAST_IDX);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        endcase
    end

    // State, counter, presented beat and captured bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {SM_IDX_W{1'b0}};
            data_q  <= {wid_out{1'b0}};
            last_q  <= 1'b0;
            for (int i = 0; i < size; i++) begin
                bank_q[i] <= {wid_out{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            for (int i = 0; i < size; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_SEND);
    assign out_data  = data_q;
    assign out_idx   = cnt_q;
    assign out_last  = last_q;

`ifdef SOFTMAX_ARGMAX_EN
    logic xfer_s;
    assign xfer_s = out_valid && out_ready;

    softmax_argmax_track #(
        .wid_out (wid_out)
    ) u_argmax (
        .clk            (clk),
        .rst            (rst),
        .beat_i         (xfer_s),
        .first_i        (cnt_q == {SM_IDX_W{1'b0}}),
        .last_i         (last_q),
        .idx_i          (cnt_q),
        .data_i         (data_q),
        .argmax_idx_o   (argmax_idx),
        .argmax_valid_o (argmax_valid)
    );
`else
    assign argmax_idx   = {SM_IDX_W{1'b0}};
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_stream_out.sv
// Randomized self-checking bench for softmax_stream_out against a queue-based model.
module tb_softmax_stream_out;

    localparam int N = 5;
    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] prob [1:N];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic [2:0]   argmax_idx;
    logic         argmax_valid;

    softmax_stream_out #(.size(N), .wid_out(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .prob         (prob),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference model: expected beats in order, expected argmax per vector.
    logic [W-1:0] exp_data_q [$];
    int           exp_idx_q  [$];
    bit           exp_last_q [$];
    int           exp_am_q   [$];
    bit mdl_idle      = 1'b1;
    bit am_due        = 1'b0;
    int am_exp        = 0;
    int am_hold       = 0;
    int cyc           = 0;
    int last_xfer_cyc = -100;
    bit b2b_mode      = 1'b0;
    int b2b_caps      = 0;

    always @(negedge clk) begin
        bit was_idle;
        int best;
        cyc++;
        if (rst) begin
            check_eq("rst_out_valid", 32'(out_valid), 32'd0);
            check_eq("rst_out_data", 32'(out_data), 32'd0);
            check_eq("rst_out_idx", 32'(out_idx), 32'd0);
            check_eq("rst_out_last", 32'(out_last), 32'd0);
            check_eq("rst_argmax_valid", 32'(argmax_valid), 32'd0);
            check_eq("rst_argmax_idx", 32'(argmax_idx), 32'd0);
            exp_data_q.delete();
            exp_idx_q.delete();
            exp_last_q.delete();
            exp_am_q.delete();
            mdl_idle = 1'b1;
            am_due   = 1'b0;
            am_hold  = 0;
        end else begin
            was_idle = mdl_idle;
            check_eq("in_ready", 32'(in_ready), 32'(was_idle));
            check_eq("out_valid", 32'(out_valid), 32'(!was_idle));
`ifdef SOFTMAX_ARGMAX_EN
            check_eq("argmax_valid", 32'(argmax_valid), 32'(am_due));
            if (am_due) am_hold = am_exp;
            check_eq("argmax_idx", 32'(argmax_idx), 32'(am_hold));
`else
            check_eq("argmax_valid_off", 32'(argmax_valid), 32'd0);
            check_eq("argmax_idx_off", 32'(argmax_idx), 32'd0);
`endif
            am_due = 1'b0;
            if (out_valid) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("beat_unexpected", 32'(exp_data_q.size()), 32'd1);
                end else begin
                    check_eq("out_data", 32'(out_data), 32'(exp_data_q[0]));
                    check_eq("out_idx", 32'(out_idx), 32'(exp_idx_q[0]));
                    check_eq("out_last", 32'(out_last), 32'(exp_last_q[0]));
                    if (out_ready) begin
                        void'(exp_data_q.pop_front());
                        void'(exp_idx_q.pop_front());
                        if (exp_last_q.pop_front()) begin
                            mdl_idle      = 1'b1;
                            am_exp        = exp_am_q.pop_front();
                            am_due        = 1'b1;
                            last_xfer_cyc = cyc;
                        end
                    end
                end
            end
            if (in_valid && was_idle) begin
                best = 1;
                for (int i = 1; i <= N; i++) begin
                    exp_data_q.push_back(prob[i]);
                    exp_idx_q.push_back(i - 1);
                    exp_last_q.push_back(i == N);
                    if (prob[i] > prob[best]) best = i;
                end
                exp_am_q.push_back(best - 1);
                mdl_idle = 1'b0;
                if (b2b_mode) begin
                    if (b2b_caps > 0) check_eq("b2b_gap", 32'(cyc - last_xfer_cyc), 32'd1);
                    b2b_caps++;
                end
            end
        end
    end

    task automatic load_vec(input logic [W-1:0] a, b, c, d, e);
        prob[1] = a; prob[2] = b; prob[3] = c; prob[4] = d; prob[5] = e;
    endtask

    // Hold in_valid until the DUT accepts, then drop it.
    task automatic capture();
        bit got = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
        end
        check_eq("capture_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk);
            done = mdl_idle && (exp_data_q.size() == 0);
            #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check_eq("drain_timeout", 32'(done), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic wait_beat(input int idx);
        bit hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            hit = out_valid && out_ready && (int'(out_idx) == idx);
        end
        check_eq("beat_wait_timeout", 32'(hit), 32'd1);
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        load_vec(17'h0, 17'h0, 17'h0, 17'h0, 17'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic streaming with out_ready held high.
        out_ready = 1'b1;
        load_vec(17'h10000, 17'h18000, 17'h10800, 17'h14000, 17'h10100);
        capture();
        drain(1'b0);

        // Backpressure: stall for three cycles while lane 2 is presented.
        load_vec(17'h11111, 17'h12222, 17'h13333, 17'h14444, 17'h15555);
        capture();
        wait_beat(1);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_idx", 32'(out_idx), 32'd2);
            check_eq("stall_data", 32'(out_data), 32'h13333);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain(1'b0);

        // All lanes tied.
        load_vec(17'h12000, 17'h12000, 17'h12000, 17'h12000, 17'h12000);
        capture();
        drain(1'b0);

        // Back-to-back vectors with in_valid held; prob changes mid-vector are ignored.
        b2b_mode = 1'b1;
        b2b_caps = 0;
        load_vec(17'h10001, 17'h10002, 17'h1F000, 17'h10004, 17'h10005);
        capture();
        in_valid = 1'b1;
        load_vec(17'h1FFFF, 17'h00001, 17'h00002, 17'h1FFFF, 17'h00003);
        capture();
        drain(1'b0);
        check_eq("b2b_captures", 32'(b2b_caps), 32'd2);
        b2b_mode = 1'b0;

        // Randomized vectors with frequent ties and random backpressure.
        for (int n = 0; n < 25; n++) begin
            for (int i = 1; i <= N; i++) begin
                v = $urandom_range(0, 1) ? 17'(17'h10000 + 17'($urandom_range(0, 3)) * 17'h01000)
                                         : 17'($urandom_range(0, 17'h1FFFF));
                prob[i] = v;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            capture();
            drain(1'b1);
        end

        // Reset mid-vector after the idx-1 transfer.
        load_vec(17'h10000, 17'h1C000, 17'h18000, 17'h14000, 17'h1E000);
        out_ready = 1'b1;
        capture();
        wait_beat(1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;

        check_eq("queue_empty", 32'(exp_data_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/softmax_stream_out.md
SOFTMAX_STREAM_OUT -- requirements
Module: softmax_stream_out

Interface
REQ-001 SHALL have parameter size, default 5, meaning number of softmax lanes per vector.
REQ-002 SHALL have parameter wid_out, default 17, meaning width of one softmax lane (leading 1 plus 16-bit shifted quotient).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning a softmax vector is presented on prob.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can capture a vector this cycle.
REQ-007 SHALL have port prob, input, [wid_out-1:0] x [1:size], the parallel softmax lane values.
REQ-008 SHALL have port out_valid, output, 1, meaning a lane value is presented on out_data.
REQ-009 SHALL have port out_ready, input, 1, meaning the downstream sink accepts the beat.
REQ-010 SHALL have port out_data, output, wid_out, the current lane value.
REQ-011 SHALL have port out_idx, output, 3, the current lane index, 0..size-1.
REQ-012 SHALL have port out_last, output, 1, marking the final lane of a vector.
REQ-013 SHALL have port argmax_idx, output, 3, the index of the largest lane of the last completed vector.
REQ-014 SHALL have port argmax_valid, output, 1, a one-cycle pulse qualifying argmax_idx.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SEND.
REQ-016 SHALL drive in_ready=1 in IDLE only and in_ready=0 in SEND.
REQ-017 SHALL, on in_valid&&in_ready, capture all size lanes into an internal register bank, clear the lane counter to 0, and move to SEND.
REQ-018 SHALL assert out_valid in the cycle after capture (capture-to-first-beat latency of 1 cycle) and hold it for as long as the FSM is in SEND.
REQ-019 SHALL present out_data = captured lane (counter+1) and out_idx = counter, both held stable while out_valid&&!out_ready.
REQ-020 SHALL advance the counter by 1 on each out_valid&&out_ready transfer.
REQ-021 SHALL assert out_last when counter == size-1.
REQ-022 SHALL, on a transfer with out_last=1, return to IDLE, so that in_ready=1 in the following cycle (one bubble cycle between vectors).
REQ-023 SHALL ignore prob and in_valid while in SEND; captured data SHALL NOT change mid-vector.
REQ-024 SHALL compare lanes as unsigned wid_out-bit values.
REQ-025 SHALL track a running maximum over transferred beats; on a tie, the lower index SHALL win.
REQ-026 SHALL pulse argmax_valid for exactly one cycle, in the cycle after the out_last transfer, and hold argmax_idx until the next pulse.
REQ-027 SHALL stall indefinitely without data loss while out_ready=0.

Reset
REQ-028 SHALL, while rst=1, force the FSM to IDLE; the counter, register bank, out_data, out_idx, argmax_idx and the running maximum to 0; and out_valid, out_last and argmax_valid to 0.
REQ-029 SHALL abort any vector in progress when rst asserts, with no argmax_valid pulse for that vector.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL gate the argmax logic with macro SOFTMAX_ARGMAX_EN.
REQ-032 SHALL, with SOFTMAX_ARGMAX_EN defined, implement REQ-025 and REQ-026.
REQ-033 SHALL, without SOFTMAX_ARGMAX_EN, tie argmax_idx and argmax_valid to 0, keep the ports present, and instantiate no compare logic.

Structure
REQ-034 SHALL place the lane count, lane width, index width and the FSM state enum in shared package softmax_pkg.
REQ-035 SHALL implement the running-max compare and update as sub-module softmax_argmax_track, instantiated only under SOFTMAX_ARGMAX_EN.

Verification
REQ-036 SHALL test basic streaming: prob = {0x10000, 0x18000, 0x10800, 0x14000, 0x10100} with out_ready held at 1 -> 5 consecutive beats, out_idx 0..4, out_last on idx 4, argmax_idx=1 pulsed once.
REQ-037 SHALL test backpressure: out_ready=0 for 3 cycles at idx 2 -> out_data and out_idx stable over those cycles, no beat lost or duplicated.
REQ-038 SHALL test ties: all lanes = 0x12000 -> argmax_idx=0.
REQ-039 SHALL test back-to-back vectors: in_valid held at 1 with two vectors -> the second is captured exactly one cycle after the first vector's last transfer, and in_ready=0 throughout SEND.
REQ-040 SHALL test reset mid-vector: rst asserted after the idx-1 transfer -> all outputs 0, no argmax_valid pulse, and in_ready=1 in the first cycle after release.
REQ-041 SHALL test the build without SOFTMAX_ARGMAX_EN: run REQ-036 -> argmax_valid remains 0 and the stream is identical.
